// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: flag indices, trapping-op
// decode constants, request record and issue FSM state encoding.
package alu_pkg;

    localparam int unsigned FLAG_OVF  = 0;
    localparam int unsigned FLAG_NEG  = 1;
    localparam int unsigned FLAG_ZERO = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD,
        DRAIN
    } issue_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    // Only the signed add/sub forms raise an overflow trap; the unsigned
    // variants (addu/addiu/subu) report the flag but never trap.
    function automatic logic is_trap_op(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        return ((op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB))) ||
               (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO holding {instruction, reg_A, reg_B} records for the issue unit.
// Caller guarantees push only when !full and pop only when !empty.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  alu_req_t wdata,
    output alu_req_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    alu_req_t         mem_q [DEPTH];
    alu_req_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Next-state for storage, pointers (wrap mod DEPTH) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/alu_issue_unit.sv
// Initiator side of the ALU interface: buffers requests, presents the FIFO
// head to the combinational ALU, and registers result/flags with trap
// classification and saturating issue/trap counters.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      alu_instr,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    input  logic [2:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags,
    output logic             out_trap,
    output logic             trap_seen,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] trap_cnt
);

    alu_req_t     wreq;
    alu_req_t     head;
    logic         fifo_full, fifo_empty;
    logic         push, cap, trap_now;

    issue_state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [2:0]       out_flags_q, out_flags_d;
    logic             out_trap_q, out_trap_d;
    logic             trap_seen_q, trap_seen_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign wreq     = '{instr: in_instr, a: in_a, b: in_b};

    alu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (cap),
        .wdata (wreq),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Present FIFO head to the ALU, forced to zero when nothing is buffered
    always_comb begin
        alu_instr = '0;
        alu_a     = '0;
        alu_b     = '0;
        if (!fifo_empty) begin
            alu_instr = head.instr;
            alu_a     = head.a;
            alu_b     = head.b;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = EXEC;
            end
            EXEC: begin
                if (out_valid_q && !out_ready && !fifo_empty) state_d = HOLD;
                else if (fifo_empty && out_valid_q)           state_d = DRAIN;
                else if (fifo_empty)                          state_d = IDLE;
            end
            HOLD: begin
                if (out_ready) state_d = EXEC;
            end
            DRAIN: begin
                if (!fifo_empty)    state_d = EXEC;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode: capture whenever a head exists and the output slot frees
    always_comb begin
        cap      = !fifo_empty && (!out_valid_q || out_ready);
        trap_now = alu_flags[FLAG_OVF] && is_trap_op(alu_instr);
    end

    // Result register, sticky trap flag and saturating counters
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_trap_d   = out_trap_q;
        trap_seen_d  = trap_seen_q;
        issue_cnt_d  = issue_cnt_q;
        trap_cnt_d   = trap_cnt_q;
        if (cap) begin
            out_valid_d  = 1'b1;
            out_instr_d  = alu_instr;
            out_result_d = alu_result;
            out_flags_d  = alu_flags;
            out_trap_d   = trap_now;
            if (trap_now) trap_seen_d = 1'b1;
            if (issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + CNT_W'(1);
            if (trap_now && (trap_cnt_q != '1)) trap_cnt_d = trap_cnt_q + CNT_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output-side registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_trap_q   <= 1'b0;
            trap_seen_q  <= 1'b0;
            issue_cnt_q  <= '0;
            trap_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_trap_q   <= out_trap_d;
            trap_seen_q  <= trap_seen_d;
            issue_cnt_q  <= issue_cnt_d;
            trap_cnt_q   <= trap_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_trap   = out_trap_q;
    assign trap_seen  = trap_seen_q;
    assign issue_cnt  = issue_cnt_q;
    assign trap_cnt   = trap_cnt_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural MIPS-style ALU
// attached to the alu_* ports.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr, in_a, in_b;
    logic [31:0] alu_instr, alu_a, alu_b;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr, out_result;
    logic [2:0]  out_flags;
    logic        out_trap;
    logic        trap_seen;
    logic [15:0] issue_cnt, trap_cnt;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic [2:0]  fl;
        logic        tr;
    } exp_t;

    always #5 clk = ~clk;

    alu_issue_unit #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_instr  (alu_instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_trap   (out_trap),
        .trap_seen  (trap_seen),
        .issue_cnt  (issue_cnt),
        .trap_cnt   (trap_cnt)
    );

    // Behavioural ALU: returns {zero, neg, ovf, result}
    function automatic logic [34:0] alu_model(input logic [31:0] ins,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] imm;
        logic        ovf;
        r   = '0;
        ovf = 1'b0;
        imm = {{16{ins[15]}}, ins[15:0]};
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20, 6'h21: begin
                        r   = a + b;
                        ovf = (a[31] == b[31]) && (r[31] != a[31]);
                    end
                    6'h22, 6'h23: begin
                        r   = a - b;
                        ovf = (a[31] != b[31]) && (r[31] != a[31]);
                    end
                    6'h24:   r = a & b;
                    6'h25:   r = a | b;
                    6'h2A:   r = {31'b0, ($signed(a) < $signed(b))};
                    default: r = '0;
                endcase
            end
            6'h08, 6'h09: begin
                r   = a + imm;
                ovf = (a[31] == imm[31]) && (r[31] != a[31]);
            end
            6'h04, 6'h05: begin
                r   = a - b;
                ovf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = '0;
        endcase
        return {(r == 32'h0), r[31], ovf, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_model(alu_instr, alu_a, alu_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and wait until its result is in the output register
    task automatic issue_one(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_instr = ins;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        else pass_cnt++;
        check_cnt++;
        if ({out_instr, out_result, out_flags, out_trap} !== 68'h0)
            $display("FAIL reset_out_regs got instr=%h res=%h fl=%b trap=%b exp all zero",
                     out_instr, out_result, out_flags, out_trap);
        else pass_cnt++;
        check_cnt++;
        if ({trap_seen, issue_cnt, trap_cnt} !== 33'h0)
            $display("FAIL reset_counters got seen=%b issue=%0d trap=%0d exp 0", trap_seen, issue_cnt, trap_cnt);
        else pass_cnt++;
        check_cnt++;
        if ({alu_instr, alu_a, alu_b} !== 96'h0)
            $display("FAIL reset_alu_zero got instr=%h a=%h b=%h exp 0", alu_instr, alu_a, alu_b);
        else pass_cnt++;
    endtask

    task automatic test_add_latency();
        in_instr = 32'h0001_0020;
        in_a     = 32'h0000_00FF;
        in_b     = 32'h0000_0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL add_valid_n1 got=%0b exp=0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (alu_instr !== 32'h0001_0020 || alu_a !== 32'h0000_00FF)
            $display("FAIL add_alu_drive got instr=%h a=%h exp 00010020 000000ff", alu_instr, alu_a);
        else pass_cnt++;
        step();
        check_cnt++;
        if (out_valid !== 1'b1 || out_result !== 32'h0000_0100 || out_flags !== 3'b000 ||
            out_trap !== 1'b0 || out_instr !== 32'h0001_0020)
            $display("FAIL add_result got v=%b res=%h fl=%b trap=%b instr=%h exp 1 00000100 000 0 00010020",
                     out_valid, out_result, out_flags, out_trap, out_instr);
        else pass_cnt++;
    endtask

    task automatic test_trap();
        issue_one(32'h0001_0020, 32'h8000_0000, 32'hFFFF_FFF1);
        check_cnt++;
        if (out_result !== 32'h7FFF_FFF1 || out_flags !== 3'b001 || out_trap !== 1'b1)
            $display("FAIL add_ovf got res=%h fl=%b trap=%b exp 7ffffff1 001 1", out_result, out_flags, out_trap);
        else pass_cnt++;
        check_cnt++;
        if (trap_seen !== 1'b1 || trap_cnt !== 16'd1)
            $display("FAIL add_ovf_cnt got seen=%b cnt=%0d exp 1 1", trap_seen, trap_cnt);
        else pass_cnt++;
        issue_one(32'h0001_0021, 32'h8000_0000, 32'hFFFF_FFF1);
        check_cnt++;
        if (out_flags !== 3'b001 || out_trap !== 1'b0 || trap_cnt !== 16'd1 || trap_seen !== 1'b1)
            $display("FAIL addu_notrap got fl=%b trap=%b cnt=%0d seen=%b exp 001 0 1 1",
                     out_flags, out_trap, trap_cnt, trap_seen);
        else pass_cnt++;
        issue_one(32'h2001_0001, 32'h7FFF_FFFF, 32'h0);
        check_cnt++;
        if (out_result !== 32'h8000_0000 || out_flags !== 3'b011 || out_trap !== 1'b1 || trap_cnt !== 16'd2)
            $display("FAIL addi_ovf got res=%h fl=%b trap=%b cnt=%0d exp 80000000 011 1 2",
                     out_result, out_flags, out_trap, trap_cnt);
        else pass_cnt++;
        issue_one(32'h2401_0001, 32'h7FFF_FFFF, 32'h0);
        check_cnt++;
        if (out_flags !== 3'b011 || out_trap !== 1'b0 || trap_cnt !== 16'd2)
            $display("FAIL addiu_notrap got fl=%b trap=%b cnt=%0d exp 011 0 2", out_flags, out_trap, trap_cnt);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        issue_one(32'h1021_0000, 32'h1FFF_FEE2, 32'h1FFF_FEE2);
        check_cnt++;
        if (out_flags !== 3'b100 || out_trap !== 1'b0 || out_result !== 32'h0)
            $display("FAIL beq_zero got fl=%b trap=%b res=%h exp 100 0 0", out_flags, out_trap, out_result);
        else pass_cnt++;
        issue_one(32'h1421_0000, 32'h0000_0005, 32'h0000_0003);
        check_cnt++;
        if (out_flags !== 3'b000 || out_trap !== 1'b0 || out_result !== 32'h2)
            $display("FAIL bne_nonzero got fl=%b trap=%b res=%h exp 000 0 2", out_flags, out_trap, out_result);
        else pass_cnt++;
        check_cnt++;
        if (issue_cnt !== 16'd7) $display("FAIL issue_cnt got=%0d exp=7", issue_cnt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_full();
        int acc;
        int k;
        int cyc;
        acc = 0;
        step();
        out_ready = 1'b0;
        in_instr  = 32'h0001_0021;
        in_b      = 32'h1;
        for (int i = 0; i < 7; i++) begin
            in_a     = 32'(i * 16);
            in_valid = 1'b1;
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        check_cnt++;
        if (acc !== 5) $display("FAIL full_accept got=%0d exp=5", acc);
        else pass_cnt++;
        check_cnt++;
        if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%0b exp=0", in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 5 && cyc < 40) begin
            if (out_valid) begin
                check_cnt++;
                if (out_result !== 32'(k * 16 + 1))
                    $display("FAIL full_order[%0d] got=%h exp=%h", k, out_result, 32'(k * 16 + 1));
                else pass_cnt++;
                k++;
            end
            step();
            cyc++;
        end
        check_cnt++;
        if (k !== 5) $display("FAIL full_drain_timeout got=%0d exp=5 results", k);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] ops [11];
        exp_t        q[$];
        exp_t        e;
        logic [34:0] m;
        logic [31:0] pi, pa, pb;
        logic        have;
        int          sent, got, cyc;
        ops = '{32'h0001_0020, 32'h0001_0021, 32'h0001_0022, 32'h0001_0023, 32'h0001_0024,
                32'h0001_0025, 32'h0001_002A, 32'h2001_8000, 32'h2401_0007, 32'h1021_0000,
                32'h1421_0000};
        have = 1'b0;
        sent = 0;
        got  = 0;
        cyc  = 0;
        pi   = '0;
        pa   = '0;
        pb   = '0;
        while (got < 20 && cyc < 1000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL stream_extra got instr=%h exp no result", out_instr);
                end else begin
                    e = q.pop_front();
                    check_cnt++;
                    if (out_instr !== e.instr || out_result !== e.res || out_flags !== e.fl || out_trap !== e.tr)
                        $display("FAIL stream[%0d] got %h/%h/%b/%b exp %h/%h/%b/%b", got,
                                 out_instr, out_result, out_flags, out_trap, e.instr, e.res, e.fl, e.tr);
                    else pass_cnt++;
                end
                got++;
            end
            if (!have && sent < 20) begin
                pi   = ops[$urandom_range(0, 10)];
                pa   = $urandom;
                pb   = $urandom;
                have = 1'b1;
            end
            in_instr = pi;
            in_a     = pa;
            in_b     = pb;
            in_valid = have && ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                m       = alu_model(pi, pa, pb);
                e.instr = pi;
                e.res   = m[31:0];
                e.fl    = m[34:32];
                e.tr    = m[32] && ((pi[31:26] == 6'h08) ||
                                    ((pi[31:26] == 6'h00) && (pi[5:0] == 6'h20 || pi[5:0] == 6'h22)));
                q.push_back(e);
                sent++;
                have = 1'b0;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_cnt++;
        if (got !== 20) $display("FAIL stream_timeout got=%0d exp=20 results", got);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int stale;
        step();
        out_ready = 1'b0;
        in_instr  = 32'h0001_0020;
        in_a      = 32'h1;
        in_b      = 32'h2;
        in_valid  = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL prereset_valid got=%0b exp=1", out_valid);
        else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || issue_cnt !== 16'd0 || trap_cnt !== 16'd0 || trap_seen !== 1'b0)
            $display("FAIL midreset_state got v=%b rdy=%b issue=%0d trap=%0d seen=%b exp 0 1 0 0 0",
                     out_valid, in_ready, issue_cnt, trap_cnt, trap_seen);
        else pass_cnt++;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid || alu_instr != 32'h0) stale++;
            step();
        end
        check_cnt++;
        if (stale !== 0) $display("FAIL midreset_stale got=%0d stale cycles exp=0", stale);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_trap();
        test_branch();
        test_back_to_back_full();
        test_stream();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
